// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: bus widths, funct3 width codes,
// FSM state encodings and the misalignment rule.
// Optional feature macro used by the unit: LSU_MISALIGN_TRAP_EN.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

package load_store_unit_pkg;

  // funct3 access width codes
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // FSM state encodings
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  // Halfwords need an even address; words (and unlisted codes) need 00.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      LSU_B, LSU_BU: is_misaligned = 1'b0;
      LSU_H, LSU_HU: is_misaligned = a[0];
      default:       is_misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational lane steering. Builds byte enables and replicated
// store data, and extracts/extends load data from the addressed lane.
// Misaligned offsets are masked: halfwords use addr_lo[1] only, words use 00.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr_lo,
  input  logic [`WORD_LEN-1:0] storeData,
  input  logic [`WORD_LEN-1:0] rdata,
  output logic [3:0]           be,
  output logic [`WORD_LEN-1:0] wdata,
  output logic [`WORD_LEN-1:0] ldata
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // Pick the addressed byte/half, then steer/extend by access width
  always_comb begin
    sel_b = rdata[{addr_lo, 3'b000} +: 8];
    sel_h = rdata[{addr_lo[1], 4'b0000} +: 16];
    be    = 4'b1111;
    wdata = storeData;
    ldata = rdata;
    case (funct3)
      LSU_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{storeData[7:0]}};
        ldata = {{24{sel_b[7]}}, sel_b};
      end
      LSU_BU: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{storeData[7:0]}};
        ldata = {24'd0, sel_b};
      end
      LSU_H: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{storeData[15:0]}};
        ldata = {{16{sel_h[15]}}, sel_h};
      end
      LSU_HU: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{storeData[15:0]}};
        ldata = {16'd0, sel_h};
      end
      default: begin
        be    = 4'b1111;
        wdata = storeData;
        ldata = rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access stage (IDLE -> REQ -> DONE).
// Bus handshake: memReq is held high with stable memAddr/memWe/memBe/memWdata
// for every REQ cycle; the access completes in the cycle memReady is high.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned accesses).
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [`ADDR_SIZE-1:0] addr,
  input  logic [`WORD_LEN-1:0]  storeData,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [`WORD_LEN-1:0]  memData,
  output logic                  memReq,
  output logic                  memWe,
  output logic [`ADDR_SIZE-1:0] memAddr,
  output logic [`WORD_LEN-1:0]  memWdata,
  output logic [3:0]            memBe,
  input  logic                  memReady,
  input  logic [`WORD_LEN-1:0]  memRdata,
  output lsu_state_t            dbg_state
);

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

  lsu_state_t           state;
  logic [2:0]           f3_q;
  logic [1:0]           alo_q;
  logic [15:0]          cnt;
  logic [2:0]           sel_f3;
  logic [1:0]           sel_alo;
  logic [3:0]           al_be;
  logic [`WORD_LEN-1:0] al_wdata;
  logic [`WORD_LEN-1:0] al_ldata;
  logic                 trap_hit;

  assign dbg_state = state;

  // Live request fields steer lanes at accept time; latched ones during REQ
  assign sel_f3  = (state == LSU_IDLE) ? funct3     : f3_q;
  assign sel_alo = (state == LSU_IDLE) ? addr[1:0]  : alo_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_hit = is_misaligned(funct3, addr[1:0]);
`else
  assign trap_hit = 1'b0;
`endif

  lsu_align u_align (
    .funct3    (sel_f3),
    .addr_lo   (sel_alo),
    .storeData (storeData),
    .rdata     (memRdata),
    .be        (al_be),
    .wdata     (al_wdata),
    .ldata     (al_ldata)
  );

  // Access sequencer with registered bus and status outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= LSU_IDLE;
      f3_q     <= 3'd0;
      alo_q    <= 2'd0;
      cnt      <= 16'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      memData  <= '0;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      memBe    <= 4'd0;
    end else begin
      case (state)
        LSU_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            if (MemRead ^ MemWrite) begin
              if (trap_hit) begin
                state <= LSU_DONE;
                done  <= 1'b1;
                err   <= 1'b1;
              end else begin
                state    <= LSU_REQ;
                f3_q     <= funct3;
                alo_q    <= addr[1:0];
                cnt      <= 16'd0;
                busy     <= 1'b1;
                memReq   <= 1'b1;
                memWe    <= MemWrite;
                memAddr  <= {addr[`ADDR_SIZE-1:2], 2'b00};
                memWdata <= al_wdata;
                memBe    <= MemWrite ? al_be : 4'b1111;
              end
            end else if (MemRead && MemWrite) begin
              // Conflicting request: complete without touching the bus
              state <= LSU_DONE;
              done  <= 1'b1;
            end
          end
        end
        LSU_REQ: begin
          if (memReady) begin
            if (!memWe) memData <= al_ldata;
            state  <= LSU_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            memReq <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
            if ((TIMEOUT_CYCLES != 0) && ((cnt + 16'd1) == TO_LIM)) begin
              state  <= LSU_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              err    <= 1'b1;
              memReq <= 1'b0;
            end
          end
        end
        LSU_DONE: begin
          state <= LSU_IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state  <= LSU_IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          err    <= 1'b0;
          memReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory access stage between the ALU and MemtoRegMux.
- Takes the ALU-computed address, store data and funct3 width code, and drives a req/ready data-memory bus with byte enables.
- Returns a sign- or zero-extended, lane-aligned load word on memData, which feeds the memData input of MemtoRegMux.
- Asserts busy so the controller can freeze the PC and pipeline registers.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles to wait for memReady before aborting; 0 disables the timeout.
- Widths come from the shared defines: `WORD_LEN (32) and `ADDR_SIZE.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request from the controller; sampled only in IDLE.
- MemRead  in  1  load request, qualified by start.
- MemWrite  in  1  store request, qualified by start.
- funct3  in  3  access width: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  `ADDR_SIZE  byte address (ALUResult).
- storeData  in  `WORD_LEN  rs2 data, right-justified.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: access aborted (misaligned or timeout).
- memData  out  `WORD_LEN  extended load result, held until the next load completes.
- memReq  out  1  bus request.
- memWe  out  1  1 = write.
- memAddr  out  `ADDR_SIZE  word-aligned address, addr with low 2 bits = 0.
- memWdata  out  `WORD_LEN  store data replicated into lanes.
- memBe  out  4  byte enables.
- memReady  in  1  bus completes the access in this cycle.
- memRdata  in  `WORD_LEN  read data, valid when memReady is high.

Behaviour:
- Reset (async, rstn=0): FSM=IDLE; busy, done, err, memReq, memWe, memBe, memAddr, memWdata, memData and the timeout counter all 0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - start with exactly one of MemRead/MemWrite set: latch funct3, addr[1:0], rw and store data, then go to REQ.
  - start with neither set: ignored.
  - start with both set: go to DONE, err=0, no bus access.
- REQ:
  - memReq=1 and bus outputs are stable throughout REQ.
  - memReady=1: capture memRdata (loads only), go to DONE.
  - Counter increments each REQ cycle; if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES without memReady, go to DONE with err=1 and memData unchanged.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
- start during REQ or DONE is ignored.
- Latency: start at cycle 0 with memReady high in the first REQ cycle gives done at cycle 2. Each wait cycle adds one.
- Store lanes:
  - sb: memBe = 0001 shifted left by addr[1:0]; the byte is replicated into all 4 lanes.
  - sh: memBe = 0011 shifted by {addr[1],0}; the half is replicated twice.
  - sw: memBe = 1111.
- Loads drive memBe=1111.
- Load extraction:
  - Select the byte or half using the latched addr[1:0].
  - b and h sign-extend; bu and hu zero-extend; w passes through.
- Unlisted funct3 codes (011, 110, 111) are treated as a word access.
- Misaligned access: h with addr[0]=1, or w with addr[1:0]≠00; handling is set by the optional feature below.
- Simultaneous events: memReady arriving on the same cycle as the timeout limit counts as success.
- Mid-operation reset: memReq drops asynchronously, and no done pulse is generated.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned start goes IDLE→DONE with err=1, no bus access, memData unchanged.
- Undefined: misaligned accesses proceed with the low address bits masked (h uses addr[1] only, w uses 00), and err is raised only on timeout.

Decomposition:
- Shared defines file holds:
  - funct3 width codes (LSU_B/H/W/BU/HU).
  - FSM state encodings (LSU_IDLE/REQ/DONE).
  - `WORD_LEN and `ADDR_SIZE.
- One natural sub-module, lsu_align: purely combinational. It generates memBe/memWdata from funct3, addr[1:0] and storeData, and extracts and extends the load data. This lets it be unit-tested exhaustively.

Test Plan:
- Load byte: memRdata=0x80FF7F01, addr=0x...03, funct3=000, memReady in first REQ cycle → done at cycle 2, memData=0xFFFFFF80. Same case with funct3=100 → memData=0x00000080.
- Store half: storeData=0x0000BEEF, addr=0x...02, funct3=001 → memBe=1100, memWdata=0xBEEFBEEF, memWe=1, memAddr low bits 00.
- Wait states: memReady held low for 3 REQ cycles → memReq stays high with stable outputs, done at cycle 5, err=0. start pulsed during REQ → ignored.
- Timeout: TIMEOUT_CYCLES=4 and memReady never asserted → done with err=1 after 4 REQ cycles, memData keeps its previous value.
- Misaligned lw at addr 0x...01:
  - With LSU_MISALIGN_TRAP_EN → done at cycle 1, err=1, memReq never asserted.
  - Without it → bus access at the aligned address, err=0.
- Reset mid-REQ: drop rstn while memReq=1 → memReq, busy, done and memData go to 0 immediately. After release the FSM is in IDLE and a fresh lw completes normally.
